// File: rtl/plane_pkg.sv
// Shared types and screen/sprite geometry for the player plane controller.
package plane_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FLY,
      ST_HIT,
      ST_RESPAWN,
      ST_OVER
   } state_t;

   localparam int SCR_W   = 640;
   localparam int SCR_H   = 480;
   localparam int PLANE_L = 40;
   localparam int PLANE_H = 40;
   localparam int COORD_W = 11;

   typedef logic [COORD_W-1:0] coord_t;

   // One axis of movement: +step for inc, -step for dec, none for both/neither,
   // then clamp to [0, lim]. One extra bit carries the sign so nothing wraps.
   function automatic coord_t step_axis(coord_t pos, logic inc, logic dec,
                                        coord_t step, coord_t lim);
      logic signed [COORD_W:0] p;
      p = signed'({1'b0, pos});
      if (inc && !dec)
         p = p + signed'({1'b0, step});
      else if (dec && !inc)
         p = p - signed'({1'b0, step});
      if (p[COORD_W])
         return '0;
      else if (p > signed'({1'b0, lim}))
         return lim;
      return p[COORD_W-1:0];
   endfunction

endpackage

// File: rtl/plane_motion_if.sv
// Frame/button/hit inputs and sprite position/status outputs of the plane controller.
interface plane_motion_if;
   logic                 frame_tick;
   logic                 btn_up;
   logic                 btn_down;
   logic                 btn_left;
   logic                 btn_right;
   logic                 btn_start;
   logic                 hit;
   plane_pkg::coord_t    poX;
   plane_pkg::coord_t    poY;
   logic                 visible;
   logic                 exploding;
   logic [1:0]           lives;
   logic                 game_over;

   modport master (
      output frame_tick, btn_up, btn_down, btn_left, btn_right, btn_start, hit,
      input  poX, poY, visible, exploding, lives, game_over
   );

   modport slave (
      input  frame_tick, btn_up, btn_down, btn_left, btn_right, btn_start, hit,
      output poX, poY, visible, exploding, lives, game_over
   );
endinterface

// File: rtl/btn_sync.sv
// Two-flop synchronizer for raw button inputs, plus a rising-edge strobe on
// the bits selected by EDGE_MASK (others read as zero).
module btn_sync #(
   parameter int              W         = 5,
   parameter logic [W-1:0]    EDGE_MASK = '1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [W-1:0]  raw,
   output logic [W-1:0]  level,
   output logic [W-1:0]  rise
);
   logic [W-1:0] s1, s2, s3;

   // synchronizer chain plus one history stage for edge detection
   always_ff @(posedge clk) begin
      if (!rst) begin
         s1 <= '0;
         s2 <= '0;
         s3 <= '0;
      end else begin
         s1 <= raw;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign level = s2;
   assign rise  = s2 & ~s3 & EDGE_MASK;
endmodule

// File: rtl/plane_motion.sv
// Player plane position and life-cycle sequencer; position updates only on frame_tick.
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | waiting for start, plane parked at spawn point
// ST_FLY     | normal flight, buttons move the plane, hit is live
// ST_HIT     | explosion animation, position frozen, counts frames
// ST_RESPAWN | invulnerable blinking flight after losing a life
// ST_OVER    | no lives left, sprite hidden until start
module plane_motion
   import plane_pkg::*;
#(
   parameter int STEP         = 4,
   parameter int START_X      = 40,
   parameter int START_Y      = 220,
   parameter int HIT_FRAMES   = 60,
   parameter int BLINK_FRAMES = 90,
   parameter int BLINK_PERIOD = 8,
   parameter int LIVES        = 3
) (
   input  logic            clk,
   input  logic            rst,
   plane_motion_if.slave   bus
);
   localparam coord_t X_MAX = coord_t'(SCR_W - PLANE_L);
   localparam coord_t Y_MAX = coord_t'(SCR_H - PLANE_H);

   logic [4:0] lvl, rise;
   logic       up, down, left, right, start_ev;

   btn_sync #(.W(5), .EDGE_MASK(5'b00001)) u_sync (
      .clk   (clk),
      .rst   (rst),
      .raw   ({bus.btn_up, bus.btn_down, bus.btn_left, bus.btn_right, bus.btn_start}),
      .level (lvl),
      .rise  (rise)
   );

   assign {up, down, left, right} = lvl[4:1];
   assign start_ev = (|rise) & lvl[0];

   state_t     state, state_nx;
   coord_t     pos_x, pos_x_nx, pos_y, pos_y_nx, mv_x, mv_y;
   logic       vis, vis_nx;
   logic [1:0] lives_r, lives_nx;
   logic [6:0] cnt, cnt_nx, cnt_inc;

   assign cnt_inc = (cnt == 7'h7f) ? cnt : cnt + 7'd1;
   assign mv_x    = step_axis(pos_x, right, left, coord_t'(STEP), X_MAX);
   assign mv_y    = step_axis(pos_y, down, up, coord_t'(STEP), Y_MAX);

   // state, position, visibility, lives and frame counter registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         state   <= ST_IDLE;
         pos_x   <= coord_t'(START_X);
         pos_y   <= coord_t'(START_Y);
         vis     <= 1'b1;
         lives_r <= 2'(LIVES);
         cnt     <= '0;
      end else begin
         state   <= state_nx;
         pos_x   <= pos_x_nx;
         pos_y   <= pos_y_nx;
         vis     <= vis_nx;
         lives_r <= lives_nx;
         cnt     <= cnt_nx;
      end
   end

   // next-state, movement, blink and life bookkeeping
   always_comb begin
      state_nx = state;
      pos_x_nx = pos_x;
      pos_y_nx = pos_y;
      vis_nx   = vis;
      lives_nx = lives_r;
      cnt_nx   = bus.frame_tick ? cnt_inc : cnt;
      case (state)
         ST_IDLE: begin
            pos_x_nx = coord_t'(START_X);
            pos_y_nx = coord_t'(START_Y);
            vis_nx   = 1'b1;
            if (start_ev) begin
               state_nx = ST_FLY;
               lives_nx = 2'(LIVES);
               cnt_nx   = '0;
            end
         end
         ST_FLY: begin
            vis_nx = 1'b1;
            // a hit on the tick cycle suppresses that frame's movement
            if (bus.hit) begin
               state_nx = ST_HIT;
               cnt_nx   = '0;
            end else if (bus.frame_tick) begin
               pos_x_nx = mv_x;
               pos_y_nx = mv_y;
            end
         end
         ST_HIT: begin
            vis_nx = 1'b1;
            if (bus.frame_tick && cnt_inc == 7'(HIT_FRAMES)) begin
               lives_nx = (lives_r != 2'd0) ? lives_r - 2'd1 : 2'd0;
               cnt_nx   = '0;
               if (lives_r <= 2'd1) begin
                  state_nx = ST_OVER;
                  vis_nx   = 1'b0;
               end else begin
                  state_nx = ST_RESPAWN;
                  pos_x_nx = coord_t'(START_X);
                  pos_y_nx = coord_t'(START_Y);
               end
            end
         end
         ST_RESPAWN: begin
            if (bus.frame_tick) begin
               pos_x_nx = mv_x;
               pos_y_nx = mv_y;
               if (cnt_inc == 7'(BLINK_FRAMES)) begin
                  state_nx = ST_FLY;
                  vis_nx   = 1'b1;
                  cnt_nx   = '0;
               end else if ((cnt_inc % 7'(BLINK_PERIOD)) == 7'd0) begin
                  vis_nx = ~vis;
               end
            end
         end
         ST_OVER: begin
            vis_nx = 1'b0;
            if (start_ev) begin
               state_nx = ST_RESPAWN;
               lives_nx = 2'(LIVES);
               pos_x_nx = coord_t'(START_X);
               pos_y_nx = coord_t'(START_Y);
               vis_nx   = 1'b1;
               cnt_nx   = '0;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   assign bus.poX       = pos_x;
   assign bus.poY       = pos_y;
   assign bus.visible   = vis;
   assign bus.exploding = (state == ST_HIT);
   assign bus.game_over = (state == ST_OVER);
   assign bus.lives     = lives_r;
endmodule
